// File: rtl/dac_stream_unpacker_pkg.sv
// Shared types and helpers for the DAC playback path: routing modes, loader states,
// and the idle/mid-scale code driven after reset.
package dac_stream_pkg;

    localparam int CH_SEL_W = 2;

    typedef enum logic [1:0] {
        CH_TEST = 2'b00,
        CH_A    = 2'b01,
        CH_B    = 2'b10,
        CH_AB   = 2'b11
    } ch_mode_e;

    typedef enum logic [1:0] {
        ST_LOAD_A = 2'b00,
        ST_LOAD_B = 2'b01,
        ST_HOLD   = 2'b10
    } fsm_state_e;

    // Mid-scale code: half range for offset binary, zero for two's complement.
    function automatic int unsigned mid_code(input int dac_w, input int offset_bin);
        if (offset_bin != 0) begin
            return 32'd1 << (dac_w - 1);
        end else begin
            return 32'd0;
        end
    endfunction

endpackage

// File: rtl/dac_stream_unpacker_sync_fifo.sv
// Single-clock FIFO with registered read data, occupancy output and synchronous flush.
// A push is refused while full regardless of a simultaneous pop.
module sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic                     i_flush,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_din,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_dout,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [LW-1:0]    r_level;
    logic [WIDTH-1:0] r_dout;
    logic             w_wr;
    logic             w_rd;

    assign o_full  = (r_level == FULL_LVL);
    assign o_empty = (r_level == {LW{1'b0}});
    assign w_wr    = i_push & ~o_full & ~i_flush;
    assign w_rd    = i_pop & ~o_empty & ~i_flush;
    assign o_dout  = r_dout;
    assign o_level = r_level;

    // Storage array, written only on an accepted push.
    always_ff @(posedge i_clk) begin
        if (w_wr) begin
            r_mem[r_wptr] <= i_din;
        end
    end

    // Pointers, occupancy and registered read port.
    always_ff @(posedge i_clk) begin
        if (i_reset || i_flush) begin
            r_wptr  <= {AW{1'b0}};
            r_rptr  <= {AW{1'b0}};
            r_level <= {LW{1'b0}};
            r_dout  <= {WIDTH{1'b0}};
        end else begin
            if (w_wr) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_rd) begin
                r_rptr <= r_rptr + AW'(1);
                r_dout <= r_mem[r_rptr];
            end
            case ({w_wr, w_rd})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase
        end
    end

endmodule

// File: rtl/dac_stream_unpacker.sv
// Host-to-DAC playback: buffers 16-bit words, stages one or two samples per tick and
// commits them to the A/B channel registers at a fixed rate (or drives a test ramp).
module dac_stream_unpacker
    import dac_stream_pkg::*;
#(
    parameter int DAC_W      = 14,
    parameter int FIFO_DEPTH = 16,
    parameter int SAMPLE_DIV = 4,
    parameter int OFFSET_BIN = 1
) (
    input  logic                        i_clk,
    input  logic                        i_reset,
    input  logic                        i_dac_en,
    input  logic [CH_SEL_W-1:0]         i_ch_sel,
    input  logic [15:0]                 i_din,
    input  logic                        i_din_valid,
    output logic                        o_din_ready,
    output logic [DAC_W-1:0]            o_dac_data_a,
    output logic [DAC_W-1:0]            o_dac_data_b,
    output logic                        o_dac_update,
    output logic                        o_underrun,
    input  logic                        i_underrun_clr,
    output logic [$clog2(FIFO_DEPTH):0] o_fifo_level
);

    localparam int CW = $clog2(SAMPLE_DIV);
    localparam logic [DAC_W-1:0] MID      = DAC_W'(mid_code(DAC_W, OFFSET_BIN));
    localparam logic [CW-1:0]    TICK_CNT = CW'(SAMPLE_DIV - 1);

    // MID is exactly the MSB mask when offset binary is enabled, and zero otherwise.
    function automatic logic [DAC_W-1:0] to_code(input logic [15:0] word);
        return word[DAC_W-1:0] ^ MID;
    endfunction

    fsm_state_e           r_state;
    fsm_state_e           w_state_nxt;
    ch_mode_e             w_mode;
    logic [CH_SEL_W-1:0]  r_ch_sel;
    logic [CW-1:0]        r_cnt;
    logic [DAC_W-1:0]     r_ramp;
    logic [DAC_W-1:0]     r_stage_a;
    logic [DAC_W-1:0]     r_stage_b;
    logic [DAC_W-1:0]     r_dac_a;
    logic [DAC_W-1:0]     r_dac_b;
    logic                 r_update;
    logic                 r_underrun;
    logic                 r_pend;
    logic                 r_pend_b;
    logic                 w_tick;
    logic                 w_sel_change;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_commit;
    logic                 w_ramp_tick;
    logic                 w_underrun_set;
    logic                 w_full;
    logic                 w_empty;
    logic [15:0]          w_rd_data;
    logic                 w_unused_rd;

    assign w_mode       = ch_mode_e'(i_ch_sel);
    assign w_sel_change = (i_ch_sel != r_ch_sel);
    assign w_tick       = i_dac_en & (r_cnt == TICK_CNT);
    assign o_din_ready  = i_dac_en & ~w_full & ~i_reset;
    assign w_push       = i_din_valid & o_din_ready;
    assign w_unused_rd  = ^w_rd_data;
    assign o_dac_data_a = r_dac_a;
    assign o_dac_data_b = r_dac_b;
    assign o_dac_update = r_update;
    assign o_underrun   = r_underrun;

    sync_fifo #(
        .WIDTH (16),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_flush (~i_dac_en),
        .i_push  (w_push),
        .i_din   (i_din),
        .i_pop   (w_pop),
        .o_dout  (w_rd_data),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (o_fifo_level)
    );

    // Loader: a mode change wins over everything that cycle, including a tick.
    always_comb begin
        w_state_nxt    = r_state;
        w_pop          = 1'b0;
        w_commit       = 1'b0;
        w_ramp_tick    = 1'b0;
        w_underrun_set = 1'b0;
        if (!i_dac_en || w_sel_change) begin
            w_state_nxt = ST_LOAD_A;
        end else if (w_mode == CH_TEST) begin
            w_state_nxt = ST_LOAD_A;
            w_ramp_tick = w_tick;
        end else begin
            case (r_state)
                ST_LOAD_A: begin
                    w_underrun_set = w_tick;
                    if (!w_empty) begin
                        w_pop       = 1'b1;
                        w_state_nxt = (w_mode == CH_AB) ? ST_LOAD_B : ST_HOLD;
                    end else begin
                        w_state_nxt = ST_LOAD_A;
                    end
                end
                ST_LOAD_B: begin
                    w_underrun_set = w_tick;
                    if (!w_empty) begin
                        w_pop       = 1'b1;
                        w_state_nxt = ST_HOLD;
                    end else begin
                        w_state_nxt = ST_LOAD_B;
                    end
                end
                ST_HOLD: begin
                    // The last popped word lands one cycle after the pop.
                    if (w_tick && !r_pend) begin
                        w_commit    = 1'b1;
                        w_state_nxt = ST_LOAD_A;
                    end else begin
                        w_underrun_set = w_tick;
                        w_state_nxt    = ST_HOLD;
                    end
                end
                default: begin
                    w_state_nxt = ST_LOAD_A;
                end
            endcase
        end
    end

    // State, rate counter, staging and output registers.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state    <= ST_LOAD_A;
            r_ch_sel   <= CH_TEST;
            r_cnt      <= {CW{1'b0}};
            r_ramp     <= {DAC_W{1'b0}};
            r_stage_a  <= {DAC_W{1'b0}};
            r_stage_b  <= {DAC_W{1'b0}};
            r_dac_a    <= MID;
            r_dac_b    <= MID;
            r_update   <= 1'b0;
            r_underrun <= 1'b0;
            r_pend     <= 1'b0;
            r_pend_b   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_ch_sel <= i_ch_sel;
            r_pend   <= w_pop;
            r_pend_b <= (r_state == ST_LOAD_B);
            r_update <= w_commit | w_ramp_tick;
            r_cnt    <= (!i_dac_en || w_tick) ? {CW{1'b0}} : r_cnt + CW'(1);
            if (!i_dac_en) begin
                r_ramp <= {DAC_W{1'b0}};
            end else if (w_ramp_tick) begin
                r_ramp <= r_ramp + DAC_W'(1);
            end
            if (r_pend) begin
                if (r_pend_b) begin
                    r_stage_b <= to_code(w_rd_data);
                end else begin
                    r_stage_a <= to_code(w_rd_data);
                end
            end
            if (w_ramp_tick) begin
                r_dac_a <= r_ramp;
                r_dac_b <= r_ramp;
            end else if (w_commit) begin
                case (w_mode)
                    CH_A:    r_dac_a <= r_stage_a;
                    CH_B:    r_dac_b <= r_stage_a;
                    CH_AB: begin
                        r_dac_a <= r_stage_a;
                        r_dac_b <= r_stage_b;
                    end
                    default: begin
                    end
                endcase
            end
            if (w_underrun_set) begin
                r_underrun <= 1'b1;
            end else if (i_underrun_clr) begin
                r_underrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_dac_stream_unpacker.sv
// Self-checking bench: directed scenarios plus randomized traffic compared every cycle
// against a queue-based model of the playback rules.
module tb_dac_stream_unpacker;

    localparam int DAC_W      = 14;
    localparam int FIFO_DEPTH = 16;
    localparam int SAMPLE_DIV = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        dac_en = 1'b0;
    logic [1:0]  ch_sel = 2'b00;
    logic [15:0] din = 16'h0000;
    logic        din_valid = 1'b0;
    logic        underrun_clr = 1'b0;
    logic        din_ready;
    logic [13:0] dac_a;
    logic [13:0] dac_b;
    logic        dac_update;
    logic        underrun;
    logic [4:0]  fifo_level;

    always #5 clk = ~clk;

    dac_stream_unpacker #(
        .DAC_W      (DAC_W),
        .FIFO_DEPTH (FIFO_DEPTH),
        .SAMPLE_DIV (SAMPLE_DIV),
        .OFFSET_BIN (1)
    ) dut (
        .i_clk          (clk),
        .i_reset        (reset),
        .i_dac_en       (dac_en),
        .i_ch_sel       (ch_sel),
        .i_din          (din),
        .i_din_valid    (din_valid),
        .o_din_ready    (din_ready),
        .o_dac_data_a   (dac_a),
        .o_dac_data_b   (dac_b),
        .o_dac_update   (dac_update),
        .o_underrun     (underrun),
        .i_underrun_clr (underrun_clr),
        .o_fifo_level   (fifo_level)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model state: FIFO as a queue, samples as a list of taken words.
    int m_q[$];
    int m_a, m_b, m_ramp, m_enc, m_ntaken, m_prev_sel, m_edge;
    int m_tv[2];
    int m_tr[2];
    bit m_upd, m_und;

    function automatic int to_code(input int word);
        return (word & 'h3FFF) ^ 'h2000;
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_a = 'h2000;
        m_b = 'h2000;
        m_ramp = 0;
        m_enc = 0;
        m_ntaken = 0;
        m_prev_sel = 0;
        m_upd = 1'b0;
        m_und = 1'b0;
    endtask

    task automatic model_step(input bit rst, input bit en, input int sel, input bit vld,
                              input int d, input bit clr);
        bit tick, change, push, done, und_set;
        int need;
        if (rst) begin
            model_reset();
            m_edge++;
            return;
        end
        m_upd   = 1'b0;
        und_set = 1'b0;
        push    = vld && en && (m_q.size() < FIFO_DEPTH);
        change  = (sel != m_prev_sel);
        m_prev_sel = sel;
        if (!en) begin
            m_q.delete();
            m_enc = 0;
            m_ramp = 0;
            m_ntaken = 0;
        end else begin
            tick = ((m_enc % SAMPLE_DIV) == SAMPLE_DIV - 1);
            m_enc++;
            if (change) begin
                m_ntaken = 0;
            end else if (sel == 0) begin
                if (tick) begin
                    m_a = m_ramp;
                    m_b = m_ramp;
                    m_ramp = (m_ramp + 1) % (1 << DAC_W);
                    m_upd = 1'b1;
                end
            end else begin
                need = (sel == 3) ? 2 : 1;
                done = 1'b0;
                if (tick) begin
                    // A sample is complete once every word of it has landed before this edge.
                    if (m_ntaken == need && m_tr[need-1] < m_edge) begin
                        done = 1'b1;
                        if (sel == 1) m_a = m_tv[0];
                        else if (sel == 2) m_b = m_tv[0];
                        else begin
                            m_a = m_tv[0];
                            m_b = m_tv[1];
                        end
                        m_ntaken = 0;
                        m_upd = 1'b1;
                    end else begin
                        und_set = 1'b1;
                    end
                end
                if (!done && m_ntaken < need && m_q.size() > 0) begin
                    m_tv[m_ntaken] = to_code(m_q.pop_front());
                    m_tr[m_ntaken] = m_edge + 1;
                    m_ntaken++;
                end
            end
            if (push) m_q.push_back(d & 'hFFFF);
        end
        if (und_set) m_und = 1'b1;
        else if (clr) m_und = 1'b0;
        m_edge++;
    endtask

    task automatic do_cycle(input bit rst, input bit en, input int sel, input bit vld,
                            input int d, input bit clr);
        @(negedge clk);
        check_val("dac_data_a", dac_a, m_a);
        check_val("dac_data_b", dac_b, m_b);
        check_val("dac_update", dac_update, m_upd);
        check_val("underrun", underrun, m_und);
        check_val("fifo_level", fifo_level, m_q.size());
        reset = rst;
        dac_en = en;
        ch_sel = sel[1:0];
        din_valid = vld;
        din = d[15:0];
        underrun_clr = clr;
        #1;
        check_val("din_ready", din_ready, (!rst && en && m_q.size() < FIFO_DEPTH));
        model_step(rst, en, sel, vld, d, clr);
    endtask

    task automatic idle(input int n, input int sel);
        for (int i = 0; i < n; i++) do_cycle(1'b0, 1'b1, sel, 1'b0, 0, 1'b0);
    endtask

    task automatic push_word(input int sel, input int d);
        do_cycle(1'b0, 1'b1, sel, 1'b1, d, 1'b0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        model_reset();
        m_edge = 0;

        // Reset state with literal expectations.
        do_cycle(1'b1, 1'b1, 0, 1'b1, 'h1234, 1'b0);
        @(posedge clk);
        #1;
        check_val("rst_a_lit", dac_a, 32'h2000);
        check_val("rst_b_lit", dac_b, 32'h2000);
        check_val("rst_ready_lit", din_ready, 32'h0);
        check_val("rst_update_lit", dac_update, 32'h0);
        check_val("rst_underrun_lit", underrun, 32'h0);

        // Channel A only: two words on successive ticks.
        push_word(1, 'h0000);
        push_word(1, 'h1FFF);
        idle(16, 1);

        // Interleaved A,B with four words.
        do_cycle(1'b1, 1'b0, 3, 1'b0, 0, 1'b0);
        for (int i = 1; i <= 4; i++) push_word(3, i);
        idle(16, 3);

        // Interleaved with a lone word: underrun, then completion and clear.
        do_cycle(1'b1, 1'b0, 3, 1'b0, 0, 1'b0);
        push_word(3, 'h0005);
        idle(12, 3);
        push_word(3, 'h0006);
        idle(10, 3);
        do_cycle(1'b0, 1'b1, 3, 1'b0, 0, 1'b1);
        idle(3, 3);

        // Test ramp: FIFO fills to the brim and stays there.
        do_cycle(1'b1, 1'b0, 0, 1'b0, 0, 1'b0);
        for (int i = 0; i < 20; i++) push_word(0, $urandom);
        @(posedge clk);
        #1;
        check_val("fill_level_lit", fifo_level, 32'd16);
        check_val("fill_ready_lit", din_ready, 32'h0);
        idle(14, 0);

        // Routing change after one word staged, then reset mid-run.
        do_cycle(1'b1, 1'b0, 3, 1'b0, 0, 1'b0);
        for (int i = 0; i < 5; i++) push_word(3, 'h0100 + i);
        push_word(1, 'h0200);
        idle(12, 1);
        do_cycle(1'b1, 1'b1, 1, 1'b0, 0, 1'b0);
        idle(6, 1);

        // Randomized traffic segments.
        for (int seg = 0; seg < 40; seg++) begin
            int sel, vprob, len;
            sel   = $urandom_range(0, 3);
            vprob = $urandom_range(5, 100);
            len   = $urandom_range(20, 90);
            for (int c = 0; c < len; c++) begin
                bit rst, en, vld, clr;
                rst = ($urandom_range(0, 299) == 0);
                en  = (seg % 7 == 6) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 199) != 0);
                vld = ($urandom_range(1, 100) <= vprob);
                clr = ($urandom_range(0, 39) == 0);
                if ($urandom_range(0, 79) == 0) sel = $urandom_range(0, 3);
                do_cycle(rst, en, sel, vld, $urandom, clr);
            end
        end

        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
